// File: rtl/s_spi_slave_core_if.sv
// Fabric-side handshake bundle of s_spi_slave_core: TX holding buffer, RX word and status pulses.
// The core uses the slave modport; the fabric (or a bench) uses the master modport.
interface s_spi_slave_core_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );
endinterface

// File: rtl/s_spi_slave_core.sv
// Oversampled SPI slave: synchronises SCLK/SS/MOSI into i_clk, all four SPI modes, MSB first.
// Define S_SPI_LSB_FIRST_EN to shift both directions LSB first.
module s_spi_slave_core #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sclk,
  input  logic               i_ss,
  input  logic               i_mosi,
  output logic               o_miso,
  s_spi_slave_core_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StActive} state_e;

  state_e                  r_state, w_state_d;
  logic [SYNC_STAGES-1:0]  r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                    r_sclk_d, r_ss_d;
  logic [CntW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0]   r_rx_shift, r_tx_shift, r_rx_data, r_buf;
  logic                    r_buf_full, r_miso, r_rx_valid, r_und, r_ferr;
  logic                    r_load_pend, r_und_pend;

  logic w_sclk, w_ss, w_mosi, w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic w_sample, w_shift, w_ss_fall, w_ss_rise, w_accept;
  logic w_load, w_shift_en, w_sample_en, w_abort, w_und;
  logic [DATA_WIDTH-1:0] w_rx_next, w_tx_next;
  logic                  w_tx_bit;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = CPHA ? w_trail : w_lead;
  assign w_shift     = CPHA ? w_lead : w_trail;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_accept    = bus.tx_valid & ~r_buf_full & (r_state != StWaitIdle);

`ifdef S_SPI_LSB_FIRST_EN
  assign w_rx_next = {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};
  assign w_tx_next = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
  assign w_tx_bit  = r_tx_shift[0];
`else
  assign w_rx_next = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
  assign w_tx_next = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign w_tx_bit  = r_tx_shift[DATA_WIDTH-1];
`endif

  // Synchronised SS resets low so a reset mid-frame waits for a real SS high before IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= CPOL;
      r_ss_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  // CPHA=0 loads the next word at the last sample, so its underrun is reported only once that
  // word actually starts; the trailing edge right after a load must not shift the fresh MSB out.
  always_comb begin
    w_state_d   = r_state;
    w_load      = 1'b0;
    w_shift_en  = 1'b0;
    w_sample_en = 1'b0;
    w_abort     = 1'b0;
    w_und       = 1'b0;
    unique case (r_state)
      StWaitIdle: if (w_ss) w_state_d = StIdle;
      StIdle: begin
        if (w_ss_fall) begin
          w_load    = 1'b1;
          w_und     = ~r_buf_full;
          w_state_d = StActive;
        end
      end
      StActive: begin
        if (w_ss_rise) begin
          w_state_d = StIdle;
          w_abort   = (r_cnt != '0);
        end else begin
          w_sample_en = w_sample;
          if (CPHA) begin
            if (w_shift && (r_cnt == '0)) begin
              w_load = r_load_pend;
              w_und  = r_load_pend & ~r_buf_full;
            end else begin
              w_shift_en = w_shift;
            end
          end else begin
            w_shift_en = w_shift && (r_cnt != '0);
            w_load     = w_sample && (r_cnt == CntLast);
            w_und      = w_sample && (r_cnt == '0) && r_und_pend;
          end
        end
      end
      default: w_state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StWaitIdle;
      r_cnt       <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_rx_data   <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_und       <= 1'b0;
      r_ferr      <= 1'b0;
      r_load_pend <= 1'b0;
      r_und_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_rx_valid <= 1'b0;
      r_und      <= w_und;
      r_ferr     <= w_abort;
      r_miso     <= w_tx_bit;

      if (w_abort) begin
        r_rx_shift <= '0;
      end else if (w_sample_en) begin
        r_rx_shift <= w_rx_next;
        if (r_cnt == CntLast) begin
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end
      end

      if (w_state_d != StActive) r_cnt <= '0;
      else if (w_sample_en)      r_cnt <= (r_cnt == CntLast) ? '0 : r_cnt + CntW'(1);

      if (w_load)          r_tx_shift <= r_buf_full ? r_buf : '0;
      else if (w_shift_en) r_tx_shift <= w_tx_next;

      if (w_accept) begin
        r_buf      <= bus.tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if (w_state_d != StActive) begin
        r_load_pend <= 1'b0;
        r_und_pend  <= 1'b0;
      end else begin
        if (CPHA && w_sample_en && (r_cnt == CntLast)) r_load_pend <= 1'b1;
        else if (w_load)                              r_load_pend <= 1'b0;
        if (!CPHA && w_load && (r_state == StActive)) r_und_pend <= ~r_buf_full;
        else if (w_sample_en && (r_cnt == '0))        r_und_pend <= 1'b0;
      end
    end
  end

  assign o_miso          = ((r_state == StActive) && !w_ss) ? r_miso : 1'bz;
  assign bus.tx_ready    = ~r_buf_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_und;
  assign bus.frame_err   = r_ferr;
  assign bus.busy        = (r_state == StActive);

endmodule

// File: tb/tb_s_spi_slave_core.sv
// Bench for s_spi_slave_core: one instance per SPI mode, a bit-level SPI master task and a
// queue-based reference model of the TX buffer / RX word stream.
module tb_s_spi_slave_core;

  localparam int Half = 5;

  logic        clk, rst;
  logic        sclk_a [4];
  logic        ss_a [4];
  logic        mosi_a [4];
  logic        miso_a [4];
  logic [31:0] tx_data_a [4];
  logic        tx_valid_a [4];
  logic        tx_ready_a [4];
  logic [31:0] rx_data_a [4];
  logic        rx_valid_a [4];
  logic        und_a [4];
  logic        ferr_a [4];
  logic        busy_a [4];

  int          rx_cnt [4];
  int          und_cnt [4];
  int          ferr_cnt [4];
  logic [31:0] rx_log [4][16];

  logic [31:0] mo_w [4];
  logic [31:0] mi_w [4];
  logic [31:0] tw [4];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wire miso_w;
    s_spi_slave_core_if #(.DATA_WIDTH(32)) u_if ();
    s_spi_slave_core #(
      .DATA_WIDTH (32),
      .CPOL       (g >= 2),
      .CPHA       ((g % 2) == 1),
      .SYNC_STAGES(2)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_sclk(sclk_a[g]),
      .i_ss  (ss_a[g]),
      .i_mosi(mosi_a[g]),
      .o_miso(miso_w),
      .bus   (u_if.slave)
    );
    assign miso_a[g]     = miso_w;
    assign u_if.tx_data  = tx_data_a[g];
    assign u_if.tx_valid = tx_valid_a[g];
    assign tx_ready_a[g] = u_if.tx_ready;
    assign rx_data_a[g]  = u_if.rx_data;
    assign rx_valid_a[g] = u_if.rx_valid;
    assign und_a[g]      = u_if.tx_underrun;
    assign ferr_a[g]     = u_if.frame_err;
    assign busy_a[g]     = u_if.busy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid_a[i]) begin
        rx_log[i][rx_cnt[i] % 16] <= rx_data_a[i];
        rx_cnt[i] <= rx_cnt[i] + 1;
      end
      if (und_a[i])  und_cnt[i]  <= und_cnt[i] + 1;
      if (ferr_a[i]) ferr_cnt[i] <= ferr_cnt[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input int m, input string tag);
    check_eq({tag, "_tx_ready"}, 32'(tx_ready_a[m]), 32'd1);
    check_eq({tag, "_rx_data"}, rx_data_a[m], 32'd0);
    check_eq({tag, "_rx_valid"}, 32'(rx_valid_a[m]), 32'd0);
    check_eq({tag, "_underrun"}, 32'(und_a[m]), 32'd0);
    check_eq({tag, "_frame_err"}, 32'(ferr_a[m]), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_a[m]), 32'd0);
  endtask

  task automatic push_tx(input int m, input logic [31:0] d);
    int t;
    t = 0;
    tx_data_a[m]  = d;
    tx_valid_a[m] = 1'b1;
    while (!tx_ready_a[m] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check_eq("tx_ready_timeout", 32'(t), 32'd0);
    @(negedge clk);
    tx_valid_a[m] = 1'b0;
  endtask

  // SPI master: nw words from mo_w (last one truncated to nlast bits), MSB first; the word
  // seen on MISO is collected into mi_w. rst_bit >= 0 pulses RST after that bit.
  task automatic spi_frame(input int m, input int nw, input int nlast, input int rst_bit);
    logic        cpol, cpha;
    logic [31:0] w;
    int          nb, gb;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    gb   = 0;
    for (int i = 0; i < 4; i++) mi_w[i] = '0;
    ss_a[m] = 1'b0;
    for (int k = 0; k < nw; k++) begin
      w  = mo_w[k];
      nb = (k == nw - 1) ? nlast : 32;
      for (int b = 0; b < nb; b++) begin
        if (!cpha) mosi_a[m] = w[31-b];
        wait_clks(Half);
        if (k == 0 && b == 2 && rst_bit < 0) check_eq("busy_in_frame", 32'(busy_a[m]), 32'd1);
        if (cpha) begin
          sclk_a[m] = ~cpol;
          mosi_a[m] = w[31-b];
        end else begin
          mi_w[k][31-b] = miso_a[m];
          sclk_a[m] = ~cpol;
        end
        wait_clks(Half);
        if (cpha) mi_w[k][31-b] = miso_a[m];
        sclk_a[m] = cpol;
        if (gb == rst_bit) begin
          rst = 1'b1;
          wait_clks(2);
          check_reset_vals(m, "mid_rst");
          rst = 1'b0;
        end
        gb++;
      end
    end
    wait_clks(Half);
    ss_a[m] = 1'b1;
    wait_clks(3 * Half);
  endtask

  // Reference model: the master sees the pushed words in order, zeros once the queue is empty;
  // the slave delivers every master word once; each word started without data is an underrun.
  task automatic xfer_check(input int m, input int nw, input int npush, input string tag);
    int          rx0, un0, fe0;
    logic [31:0] q[$];
    logic [31:0] exp;
    rx0 = rx_cnt[m];
    un0 = und_cnt[m];
    fe0 = ferr_cnt[m];
    q   = {};
    for (int k = 0; k < npush; k++) q.push_back(tw[k]);
    if (npush > 0) push_tx(m, tw[0]);
    fork
      spi_frame(m, nw, 32, -1);
      begin
        for (int k = 1; k < npush; k++) push_tx(m, tw[k]);
      end
    join
    for (int k = 0; k < nw; k++) begin
      exp = (q.size() > 0) ? q.pop_front() : 32'd0;
      check_eq($sformatf("%s_miso%0d", tag, k), mi_w[k], exp);
      check_eq($sformatf("%s_rx%0d", tag, k), rx_log[m][(rx0 + k) % 16], mo_w[k]);
    end
    check_eq({tag, "_rx_count"}, 32'(rx_cnt[m] - rx0), 32'(nw));
    check_eq({tag, "_underruns"}, 32'(und_cnt[m] - un0), 32'((nw > npush) ? nw - npush : 0));
    check_eq({tag, "_frame_errs"}, 32'(ferr_cnt[m] - fe0), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy_a[m]), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, nw, np, rx0, fe0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_a[i]     = (i >= 2);
      ss_a[i]       = 1'b1;
      mosi_a[i]     = 1'b0;
      tx_data_a[i]  = '0;
      tx_valid_a[i] = 1'b0;
    end
    wait_clks(5);
    for (int i = 0; i < 4; i++) check_reset_vals(i, $sformatf("reset%0d", i));
    rst = 1'b0;
    wait_clks(10);

    mo_w[0] = 32'h1234_5678;
    tw[0]   = 32'hA5C3_0F96;
    xfer_check(0, 1, 1, "mode0");

    for (int i = 1; i < 4; i++) begin
      mo_w[0] = 32'hDEAD_BEEF;
      tw[0]   = 32'hCAFE_F00D;
      xfer_check(i, 1, 1, $sformatf("mode%0d", i));
    end

    for (int i = 0; i < 4; i += 3) begin
      mo_w[0] = 32'h1;
      mo_w[1] = 32'h2;
      mo_w[2] = 32'h3;
      for (int k = 0; k < 3; k++) tw[k] = $urandom;
      xfer_check(i, 3, 3, $sformatf("b2b_m%0d", i));
    end

    mo_w[0] = $urandom;
    xfer_check(0, 1, 0, "empty");

    rx0 = rx_cnt[2];
    fe0 = ferr_cnt[2];
    mo_w[0] = $urandom;
    spi_frame(2, 1, 13, -1);
    check_eq("abort_frame_errs", 32'(ferr_cnt[2] - fe0), 32'd1);
    check_eq("abort_rx_count", 32'(rx_cnt[2] - rx0), 32'd0);
    mo_w[0] = 32'h0BAD_CAFE;
    tw[0]   = $urandom;
    xfer_check(2, 1, 1, "after_abort");

    rx0 = rx_cnt[0];
    fe0 = ferr_cnt[0];
    mo_w[0] = $urandom;
    spi_frame(0, 1, 32, 7);
    check_eq("rst_frame_rx_count", 32'(rx_cnt[0] - rx0), 32'd0);
    check_eq("rst_frame_errs", 32'(ferr_cnt[0] - fe0), 32'd0);
    wait_clks(10);
    mo_w[0] = $urandom;
    tw[0]   = $urandom;
    xfer_check(0, 1, 1, "after_rst");

    for (int r = 0; r < 8; r++) begin
      m  = int'($urandom_range(0, 3));
      nw = int'($urandom_range(1, 3));
      np = int'($urandom_range(0, nw));
      for (int k = 0; k < 3; k++) begin
        mo_w[k] = $urandom;
        tw[k]   = $urandom;
      end
      xfer_check(m, nw, np, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s_spi_slave_core.md
# s_spi_slave_core

Parametrised, system-clocked SPI slave: synchronises SCLK/SS/MOSI into the `CLK` domain, supports all four SPI modes and configurable word width, and exchanges words with the fabric over valid/ready-style handshakes. It is the next-generation slave front end. It sits between the board SPI pins and the slave's register/command logic. It replaces direct SCLK-clocked capture with oversampled, single-clock-domain logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bits per SPI word (2..64).
- `CPOL`, 0: idle SCLK level.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `SYNC_STAGES`, 2: synchroniser depth for SCLK, SS, MOSI (2..3).

Ports:
- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: reset is synchronous and active-high.
- `SCLK` in 1: SPI clock, asynchronous.
- `SS` in 1: slave select, active-low, asynchronous.
- `MOSI` in 1: master data in.
- `MISO` out 1: master data out; `1'bz` while synchronised SS is high.
- `tx_data` in DATA_WIDTH: next word to transmit.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: TX holding buffer empty.
- `rx_data` out DATA_WIDTH: last complete received word.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `tx_underrun` out 1: one-cycle pulse, a word started with an empty buffer.
- `frame_err` out 1: one-cycle pulse, SS rose mid-word.
- `busy` out 1: high in ACTIVE state.

## Operation
- Each async input passes through `SYNC_STAGES` flops. Edges are detected on synchronised SCLK/SS by comparison with a one-cycle-delayed copy.
- Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading (CPHA=0) or trailing (CPHA=1). Shift edge = the other one.
- MSB first. Bit counter is `$clog2(DATA_WIDTH)` wide and counts sample edges 0..DATA_WIDTH-1.
- States:
  - WAIT_IDLE: entered on reset. Moves to IDLE once synchronised SS is seen high. This stops a reset in mid-frame from joining a frame partway.
  - IDLE: SS high, MISO z. SS falling edge causes a word load (below), then a move to ACTIVE.
  - ACTIVE: sample edge shifts MOSI into rx shift reg and increments the counter. Shift edge shifts the tx reg and drives the next bit on MISO. After DATA_WIDTH samples, `rx_data` takes the full word, `rx_valid` pulses, the counter wraps to 0, and a word load occurs for back-to-back words (CPHA=0: at that sample; CPHA=1: at the next leading edge). SS rising edge returns to IDLE.
- Word load: if the TX buffer is full, the tx shift reg takes the buffer and the buffer empties (`tx_ready` rises the next cycle). Otherwise the tx shift reg takes all-zeros and `tx_underrun` pulses.
- TX buffer accepts on `tx_valid && tx_ready` in any state except WAIT_IDLE. If acceptance and load occur in the same cycle, the load uses the old buffer contents (underrun if empty), and the accepted word is kept for the next word.
- SS rise with counter ≠ 0: partial rx bits are discarded, `frame_err` pulses, `rx_valid` does not pulse, and the counter clears. SS rise with counter = 0 is a clean end.
- Reset values: `MISO` z, `tx_ready` 1, `rx_data` 0, `rx_valid`/`tx_underrun`/`frame_err`/`busy` 0, counter 0, buffer empty.

## Timing
- Input-to-detect latency: `SYNC_STAGES`+1 CLK cycles from a pin edge.
- `rx_valid` asserts `SYNC_STAGES`+2 cycles after the last sample pin edge.
- MISO updates `SYNC_STAGES`+2 cycles after a shift pin edge (or after SS fall for bit 0 when CPHA=0).
- Constraint: each SCLK half-period ≥ `SYNC_STAGES`+3 CLK cycles. SS fall to first SCLK edge ≥ `SYNC_STAGES`+3 CLK cycles. With default params, f_SCLK ≤ f_CLK/10.
- `tx_data` must be accepted at least 1 CLK cycle before the internal word-load cycle to avoid underrun.

## Configuration
- `S_SPI_LSB_FIRST_EN`:
  - Defined: both the rx and tx shift registers run LSB first; bit 0 is the first on the wire.
  - Undefined (default): MSB first.
  - Handshakes and timing are identical in both cases.

## Test plan
- Mode 0, DATA_WIDTH=32, CLK/SCLK=10: preload `tx_data`=0xA5C3_0F96 → master receives 0xA5C3_0F96; master sends 0x1234_5678 → one `rx_valid` pulse with `rx_data`=0x1234_5678; `tx_underrun`=0.
- Modes 1, 2, 3 each: master sends 0xDEAD_BEEF with slave tx 0xCAFE_F00D → both words match at both ends.
- Back-to-back: SS held low for 3 words (0x1, 0x2, 0x3), tx refilled via handshake → 3 `rx_valid` pulses in order, MISO carries the 3 tx words with no gap.
- Empty buffer: SS falls with `tx_ready`=1 → `tx_underrun` pulses once, MISO shifts 0x0000_0000, rx still correct.
- SS rises after 13 bits → `frame_err` pulses once, no `rx_valid`; the next full frame 0x0BAD_CAFE is received correctly.
- `RST` pulsed mid-frame at bit 7 with SS held low → outputs at reset values; the remaining bits of that frame are ignored; the next frame after SS high→low is received correctly.
